// File: rtl/regfile_console_pkg.sv
// Shared constants for the register-file console: display modes, button indices and FSM states.
package regfile_console_pkg;

    localparam logic [1:0] MODE_RA  = 2'd0;
    localparam logic [1:0] MODE_RB  = 2'd1;
    localparam logic [1:0] MODE_BUF = 2'd2;
    localparam logic [1:0] MODE_SW  = 2'd3;

    localparam int BTN_W      = 6;
    localparam int BTN_SHOWA  = 0;
    localparam int BTN_SHOWB  = 1;
    localparam int BTN_LOAD   = 2;
    localparam int BTN_COMMIT = 3;
    localparam int BTN_SHOWSW = 4;
    localparam int BTN_CLEAR  = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_core.sv
// WIDTH x DEPTH register array: two combinational read ports, one synchronous write port, synchronous clear.
module regfile_core #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ZERO_REG0 = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_ok;

    // An address is usable when it exists and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !((ZERO_REG0 != 0) && (a == {AW{1'b0}}));
    endfunction

    assign w_wr_ok   = i_we && addr_ok(i_waddr);
    assign o_rdata_a = addr_ok(i_raddr_a) ? r_mem[i_raddr_a] : {WIDTH{1'b0}};
    assign o_rdata_b = addr_ok(i_raddr_b) ? r_mem[i_raddr_b] : {WIDTH{1'b0}};

    // Array storage: reset/clear zero every entry; clear outranks a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/regfile_console.sv
// Register-file console top: button conditioning, two-step write FSM, data buffer and registered display mux.
module regfile_console
    import regfile_console_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ZERO_REG0 = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       btn,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] disp_data,
    output logic [1:0]       disp_mode,
    output logic             wr_pending,
    output logic             wr_strobe
);

    localparam int AW = $clog2(DEPTH);

    logic [BTN_W-1:0] r_btn_s1, r_btn_s2, r_btn_d;
    logic [WIDTH-1:0] r_sw_q, r_data_buf;
    state_t           r_state;
    logic [BTN_W-1:0] w_edge, w_act;
    logic [WIDTH-1:0] w_rd_a, w_rd_b;
    logic             w_we;

    // Two-flop synchroniser, edge-detect delay stage and switch sampling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_s1 <= {BTN_W{1'b0}};
            r_btn_s2 <= {BTN_W{1'b0}};
            r_btn_d  <= {BTN_W{1'b0}};
            r_sw_q   <= {WIDTH{1'b0}};
        end else begin
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_sw_q   <= sw;
        end
    end

    assign w_edge = r_btn_s2 & ~r_btn_d;

    // Only the highest-priority edge in a cycle is allowed to act.
    always_comb begin
        w_act = {BTN_W{1'b0}};
        if (w_edge[BTN_CLEAR])       w_act[BTN_CLEAR]  = 1'b1;
        else if (w_edge[BTN_SHOWA])  w_act[BTN_SHOWA]  = 1'b1;
        else if (w_edge[BTN_SHOWB])  w_act[BTN_SHOWB]  = 1'b1;
        else if (w_edge[BTN_LOAD])   w_act[BTN_LOAD]   = 1'b1;
        else if (w_edge[BTN_COMMIT]) w_act[BTN_COMMIT] = 1'b1;
        else if (w_edge[BTN_SHOWSW]) w_act[BTN_SHOWSW] = 1'b1;
        else                         w_act = {BTN_W{1'b0}};
    end

    assign w_we = w_act[BTN_COMMIT] && (r_state == ST_LOADED);

    regfile_core #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ZERO_REG0 (ZERO_REG0),
        .AW        (AW)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_act[BTN_CLEAR]),
        .i_we      (w_we),
        .i_waddr   (r_sw_q[WIDTH-1 -: AW]),
        .i_wdata   (r_data_buf),
        .i_raddr_a (r_sw_q[AW-1:0]),
        .i_raddr_b (r_sw_q[2*AW-1:AW]),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Write FSM with registered mode, pending flag and strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_data_buf <= {WIDTH{1'b0}};
            disp_mode  <= MODE_SW;
            wr_pending <= 1'b0;
            wr_strobe  <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (w_act[BTN_CLEAR]) begin
                r_state    <= ST_IDLE;
                r_data_buf <= {WIDTH{1'b0}};
                disp_mode  <= MODE_SW;
                wr_pending <= 1'b0;
            end else if (w_act[BTN_SHOWA]) begin
                disp_mode <= MODE_RA;
            end else if (w_act[BTN_SHOWB]) begin
                disp_mode <= MODE_RB;
            end else if (w_act[BTN_LOAD]) begin
                r_data_buf <= r_sw_q;
                disp_mode  <= MODE_BUF;
                r_state    <= ST_LOADED;
                wr_pending <= 1'b1;
            end else if (w_act[BTN_COMMIT]) begin
                disp_mode <= MODE_SW;
                case (r_state)
                    ST_LOADED: begin
                        wr_strobe  <= 1'b1;
                        r_state    <= ST_IDLE;
                        wr_pending <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_act[BTN_SHOWSW]) begin
                disp_mode <= MODE_SW;
            end
        end
    end

    // Display word trails the selected source by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_data <= {WIDTH{1'b0}};
        end else begin
            case (disp_mode)
                MODE_RA:  disp_data <= w_rd_a;
                MODE_RB:  disp_data <= w_rd_b;
                MODE_BUF: disp_data <= r_data_buf;
                default:  disp_data <= r_sw_q;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_console.sv
// Directed bench for regfile_console: a 32x32 instance and a 32x24 instance share all stimulus.
module tb_regfile_console;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  btn = 6'd0;
    logic [31:0] sw = 32'd0;
    logic [31:0] d32, d24;
    logic [1:0]  m32, m24;
    logic        p32, p24, s32, s24;
    int          cnt32 = 0, cnt24 = 0;
    int          n_vec = 0, n_err = 0;

    typedef struct {
        logic [5:0]  btn;
        logic [31:0] sw;
        logic [1:0]  mode;
        logic [31:0] data;
        logic [31:0] data24;
        logic        pend;
        int          strobes;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    regfile_console #(.WIDTH(32), .DEPTH(32), .ZERO_REG0(1)) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn), .sw(sw),
        .disp_data(d32), .disp_mode(m32), .wr_pending(p32), .wr_strobe(s32));

    regfile_console #(.WIDTH(32), .DEPTH(24), .ZERO_REG0(1)) dut24 (
        .clk(clk), .reset_n(reset_n), .btn(btn), .sw(sw),
        .disp_data(d24), .disp_mode(m24), .wr_pending(p24), .wr_strobe(s24));

    always @(negedge clk) begin
        if (s32) cnt32 <= cnt32 + 1;
        if (s24) cnt24 <= cnt24 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] b, input logic [31:0] s, input logic [1:0] m,
                       input logic [31:0] d, input logic [31:0] d2, input logic p, input int st);
        vec_t v;
        v.btn = b; v.sw = s; v.mode = m; v.data = d; v.data24 = d2; v.pend = p; v.strobes = st;
        vq.push_back(v);
    endtask

    task automatic press(input vec_t v, input string tag);
        int c32, c24;
        @(negedge clk); #1;
        sw = v.sw; c32 = cnt32; c24 = cnt24;
        repeat (2) @(negedge clk);
        btn = v.btn;
        repeat (2) @(negedge clk);
        btn = 6'd0;
        repeat (6) @(negedge clk);
        #1;
        check({tag, " mode"},     {30'd0, m32}, {30'd0, v.mode});
        check({tag, " mode24"},   {30'd0, m24}, {30'd0, v.mode});
        check({tag, " data"},     d32, v.data);
        check({tag, " data24"},   d24, v.data24);
        check({tag, " pending"},  {31'd0, p32}, {31'd0, v.pend});
        check({tag, " strobes"},  32'(cnt32 - c32), 32'(v.strobes));
        check({tag, " strobes24"}, 32'(cnt24 - c24), 32'(v.strobes));
    endtask

    task automatic sweep_zero(input string tag);
        vec_t v;
        for (int a = 0; a < 32; a++) begin
            v.btn = 6'b000001; v.sw = 32'(a); v.mode = 2'd0;
            v.data = 32'd0; v.data24 = 32'd0; v.pend = 1'b0; v.strobes = 0;
            press(v, $sformatf("%s a%0d", tag, a));
        end
    endtask

    initial begin
        vec_t v;
        // Table: write/read-back, zero register, commit without load, priority, DEPTH=24 range,
        // show while LOADED, re-load, clear from LOADED.
        add(6'b000100, 32'hDEADBEEF, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0);
        add(6'b001000, 32'h28000000, 2'd3, 32'h28000000, 32'h28000000, 1'b0, 1);
        add(6'b000001, 32'h00000005, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        add(6'b000010, 32'h000000A0, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        add(6'b000100, 32'h12345678, 2'd2, 32'h12345678, 32'h12345678, 1'b1, 0);
        add(6'b001000, 32'h00000000, 2'd3, 32'h00000000, 32'h00000000, 1'b0, 1);
        add(6'b000001, 32'h00000000, 2'd0, 32'h00000000, 32'h00000000, 1'b0, 0);
        add(6'b001000, 32'h00000005, 2'd3, 32'h00000005, 32'h00000005, 1'b0, 0);
        add(6'b000001, 32'h00000005, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        add(6'b000110, 32'h000000A0, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
        add(6'b000100, 32'h0BADF00D, 2'd2, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 0);
        add(6'b001000, 32'hF0000000, 2'd3, 32'hF0000000, 32'hF0000000, 1'b0, 1);
        add(6'b000001, 32'h0000001E, 2'd0, 32'h0BADF00D, 32'h00000000, 1'b0, 0);
        add(6'b010000, 32'h5555AAAA, 2'd3, 32'h5555AAAA, 32'h5555AAAA, 1'b0, 0);
        add(6'b000100, 32'h11111111, 2'd2, 32'h11111111, 32'h11111111, 1'b1, 0);
        add(6'b000001, 32'h00000005, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0);
        add(6'b001000, 32'h08000000, 2'd3, 32'h08000000, 32'h08000000, 1'b0, 1);
        add(6'b000001, 32'h00000001, 2'd0, 32'h11111111, 32'h11111111, 1'b0, 0);
        add(6'b000100, 32'h22222222, 2'd2, 32'h22222222, 32'h22222222, 1'b1, 0);
        add(6'b000100, 32'h33333333, 2'd2, 32'h33333333, 32'h33333333, 1'b1, 0);
        add(6'b001000, 32'h10000000, 2'd3, 32'h10000000, 32'h10000000, 1'b0, 1);
        add(6'b000001, 32'h00000002, 2'd0, 32'h33333333, 32'h33333333, 1'b0, 0);
        add(6'b000100, 32'h44444444, 2'd2, 32'h44444444, 32'h44444444, 1'b1, 0);
        add(6'b001000, 32'h18000000, 2'd3, 32'h18000000, 32'h18000000, 1'b0, 1);
        add(6'b000001, 32'h00000003, 2'd0, 32'h44444444, 32'h44444444, 1'b0, 0);
        add(6'b000100, 32'h77777777, 2'd2, 32'h77777777, 32'h77777777, 1'b1, 0);
        add(6'b100001, 32'h00000003, 2'd3, 32'h00000003, 32'h00000003, 1'b0, 0);
        add(6'b001000, 32'h08000000, 2'd3, 32'h08000000, 32'h08000000, 1'b0, 0);

        repeat (3) @(negedge clk);
        #1;
        check("reset mode",    {30'd0, m32}, 32'd3);
        check("reset data",    d32, 32'd0);
        check("reset pending", {31'd0, p32}, 32'd0);
        check("reset strobe",  {31'd0, s32}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Latency: the third rising edge after btn is first sampled performs the action.
        btn = 6'b000001;
        repeat (2) @(posedge clk);
        #1 check("latency edge2 mode", {30'd0, m32}, 32'd3);
        @(posedge clk);
        #1 check("latency edge3 mode", {30'd0, m32}, 32'd0);
        @(negedge clk);
        btn = 6'd0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < vq.size(); i++) press(vq[i], $sformatf("vec%0d", i));
        sweep_zero("after clear");

        // Held load: one capture only, later switch changes are ignored.
        @(negedge clk);
        sw = 32'h600DCAFE;
        repeat (2) @(negedge clk);
        btn = 6'b000100;
        repeat (10) @(negedge clk);
        sw = 32'hBAD0BAD0;
        repeat (90) @(negedge clk);
        btn = 6'd0;
        repeat (6) @(negedge clk);
        #1;
        check("held mode",    {30'd0, m32}, 32'd2);
        check("held data",    d32, 32'h600DCAFE);
        check("held pending", {31'd0, p32}, 32'd1);
        v.btn = 6'b001000; v.sw = 32'h20000000; v.mode = 2'd3; v.data = 32'h20000000;
        v.data24 = 32'h20000000; v.pend = 1'b0; v.strobes = 1;
        press(v, "held commit");
        v.btn = 6'b000001; v.sw = 32'h00000004; v.mode = 2'd0; v.data = 32'h600DCAFE;
        v.data24 = 32'h600DCAFE; v.pend = 1'b0; v.strobes = 0;
        press(v, "held readback");

        // Reset while LOADED drops the pending write and clears everything.
        v.btn = 6'b000100; v.sw = 32'hCAFEF00D; v.mode = 2'd2; v.data = 32'hCAFEF00D;
        v.data24 = 32'hCAFEF00D; v.pend = 1'b1; v.strobes = 0;
        press(v, "rst load");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst pending", {31'd0, p32}, 32'd0);
        check("rst mode",    {30'd0, m32}, 32'd3);
        check("rst data",    d32, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        v.btn = 6'b001000; v.sw = 32'h20000000; v.mode = 2'd3; v.data = 32'h20000000;
        v.data24 = 32'h20000000; v.pend = 1'b0; v.strobes = 0;
        press(v, "rst commit");
        sweep_zero("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
